// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of signed products (for
// example, from a 32x32 multiplier) into a wide two's-complement accumulator.
// Input and output each use a valid/ready handshake. The handshake outputs
// depend only on the FSM state, so there is no combinational path from
// in_valid to in_ready, or from out_ready to out_valid.
module product_accumulator #(
    parameter int PW    = 64,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_nxt;
    logic             add_ovf;

    // Sign-extend the product. Overflow means the operands share a sign and
    // the wrapped result does not.
    assign prod_ext = ACC_W'($signed(in_prod));
    assign sum_nxt  = acc + prod_ext;
    assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_nxt[ACC_W-1] != acc[ACC_W-1]);

    // Run control: a start pulse in IDLE loads len, ACC accepts products,
    // and DONE holds the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (len != '0) begin
                            cnt   <= len;
                            state <= ACC;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= sum_nxt;
                        ovf <= ovf | add_ovf;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded from state alone. out_sum keeps the last
    // result after the drain, because acc is only cleared by start or rst.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. The default 72-bit build and a
// 64-bit build share all inputs. The 64-bit build is used for the overflow
// case. Expected results are queued when a run is fed and popped at drain.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  len;
    logic [63:0] in_prod;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [71:0] out_sum;
    logic        in_ready64, out_valid64, out_ovf64, busy64;
    logic [63:0] out_sum64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [71:0] s72;
        logic        o72;
        logic [63:0] s64;
        logic        o64;
    } exp_t;
    exp_t        sb[$];
    logic [71:0] m72;
    logic        mo72;
    logic [63:0] m64;
    logic        mo64;

    product_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    product_accumulator #(.ACC_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready64), .in_prod(in_prod),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_sum(out_sum64), .out_ovf(out_ovf64), .busy(busy64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: detect overflow from the exact sum one bit wider than the accumulator.
    task automatic m_add(input logic [63:0] p);
        logic [72:0] w72;
        logic [64:0] w64;
        w72 = {{9{p[63]}}, p[63], p} + {m72[71], m72};
        w64 = {p[63], p} + {m64[63], m64};
        if (w72[72] != w72[71]) mo72 = 1'b1;
        if (w64[64] != w64[63]) mo64 = 1'b1;
        m72 = w72[71:0];
        m64 = w64[63:0];
    endtask

    task automatic m_push();
        exp_t e;
        e.s72 = m72; e.o72 = mo72; e.s64 = m64; e.o64 = mo64;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1; len = l;
        step();
        start = 1'b0;
        m72 = '0; mo72 = 1'b0; m64 = '0; mo64 = 1'b0;
    endtask

    task automatic feed(input logic [63:0] p);
        in_valid = 1'b1; in_prod = p;
        step();
        in_valid = 1'b0; in_prod = 64'hDEAD;
        m_add(p);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_prod = 64'h3E7;
        step();
    endtask

    // Wait for the result (bounded), compare it, hold it for `hold` cycles,
    // then take it. `st` pulses start on the take cycle, which must be ignored.
    task automatic drain(input int hold, input logic st);
        int   t;
        exp_t e;
        t = 0;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        chk("out_valid_wait", out_valid, 1);
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            chk("sum72", out_sum, e.s72);
            chk("ovf72", out_ovf, e.o72);
            chk("sum64", out_sum64, e.s64);
            chk("ovf64", out_ovf64, e.o64);
            chk("in_ready_done", in_ready, 0);
            for (int i = 0; i < hold; i++) begin
                out_ready = 1'b0;
                step();
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, e.s72);
            end
            out_ready = 1'b1; start = st; len = 8'd3;
            step();
            out_ready = 1'b0; start = 1'b0;
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
            chk("sum_kept", out_sum, e.s72);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_prod = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Single product
        do_start(8'd1);
        chk("acc_in_ready", in_ready, 1);
        chk("acc_busy", busy, 1);
        feed(-64'sd16);
        chk("single_latency", out_valid, 1);
        chk("single_sum", out_sum, {{68{1'b1}}, 4'h0});
        m_push();
        drain(0, 1'b0);

        // Four-term dot product, back to back
        do_start(8'd4);
        feed(64'd6); feed(-64'sd15); feed(64'd100);
        chk("dot_not_yet", out_valid, 0);
        feed(-64'sd1);
        chk("dot_valid", out_valid, 1);
        chk("dot_const", out_sum, 72'd90);
        m_push();
        drain(0, 1'b0);

        // Input stalls, then a held output
        do_start(8'd3);
        feed(64'd10); idle_in(); idle_in();
        chk("stall_ready", in_ready, 1);
        chk("stall_valid", out_valid, 0);
        feed(-64'sd3); idle_in();
        chk("stall_valid2", out_valid, 0);
        feed(64'd20);
        chk("stall_const", out_sum, 72'd27);
        m_push();
        drain(5, 1'b0);

        // Empty run
        do_start(8'd0);
        chk("empty_valid", out_valid, 1);
        chk("empty_sum", out_sum, 0);
        m_push();
        drain(0, 1'b0);

        // Start during ACC is ignored. Start on the take cycle is ignored too.
        do_start(8'd2);
        feed(64'd40);
        start = 1'b1; len = 8'd5;
        feed(64'd2);
        start = 1'b0;
        chk("ign_start_done", out_valid, 1);
        chk("ign_start_sum", out_sum, 72'd42);
        m_push();
        drain(1, 1'b1);
        step();
        chk("ign_start_idle", busy, 0);

        // Overflow on the 64-bit build; the 72-bit build absorbs it
        do_start(8'd2);
        feed(64'h7FFF_FFFF_FFFF_FFFF); feed(64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf64_sum", out_sum64, 72'hFFFF_FFFF_FFFF_FFFE);
        chk("ovf64_flag", out_ovf64, 1);
        chk("ovf72_sum", out_sum, 72'h00_FFFF_FFFF_FFFF_FFFE);
        chk("ovf72_flag", out_ovf, 0);
        m_push();
        drain(0, 1'b0);
        do_start(8'd1);
        feed(64'd5);
        chk("ovf_cleared", out_ovf64, 0);
        m_push();
        drain(0, 1'b0);

        // Reset mid-run discards the partial sum
        do_start(8'd4);
        feed(64'd11); feed(64'd12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_ovf", out_ovf, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        chk("mid_rst_no_out", out_valid, 0);
        do_start(8'd1);
        feed(64'd7);
        chk("fresh_sum", out_sum, 72'd7);
        m_push();
        drain(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
